// File: rtl/calc_display_if.sv
// Purpose: bundles the calculator-side digit bus and the board-side display pins.
// Latency: none, wiring only.
// Backpressure: none; the calculator drives pos/data/status freely every cycle.
interface calc_display_if #(
   parameter int NUM_DIGITS = 8
);
   logic [3:0]            data;
   logic [3:0]            pos;
   logic [1:0]            status;
   logic [6:0]            seg;
   logic                  dp;
   logic [NUM_DIGITS-1:0] an;

   // Calculator / stimulus side
   modport master (output data, pos, status, input seg, dp, an);
   // Display controller side
   modport slave  (input data, pos, status, output seg, dp, an);
endinterface

// File: rtl/calc_display_ctrl.sv
// Purpose: nibble register file scanned onto common-anode 7-segment digits, with error/busy override.
// Latency: 1 cycle from scan index / register file / status to seg and an.
// Backpressure: none; writes land every cycle pos is in range, out-of-range pos is ignored.
module calc_display_ctrl #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 50000
) (
   input  logic          clock,
   input  logic          reset,
   calc_display_if.slave bus
);
   localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNTW = $clog2(REFRESH_DIV);

   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_R     = 7'b0101111;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

   logic [3:0]            digit [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] valid;
   logic [IDXW-1:0]       scan_idx;
   logic [CNTW-1:0]       tick;
   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            glyph;
   logic [NUM_DIGITS-1:0] an_nxt;

   // Active-low hex decode, segment order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: hex_glyph = 7'b1000000;
         4'h1: hex_glyph = 7'b1111001;
         4'h2: hex_glyph = 7'b0100100;
         4'h3: hex_glyph = 7'b0110000;
         4'h4: hex_glyph = 7'b0011001;
         4'h5: hex_glyph = 7'b0010010;
         4'h6: hex_glyph = 7'b0000010;
         4'h7: hex_glyph = 7'b1111000;
         4'h8: hex_glyph = 7'b0000000;
         4'h9: hex_glyph = 7'b0010000;
         4'hA: hex_glyph = 7'b0001000;
         4'hB: hex_glyph = 7'b0000011;
         4'hC: hex_glyph = 7'b1000110;
         4'hD: hex_glyph = 7'b0100001;
         4'hE: hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   // Register file: strobe-less write whenever pos addresses a real digit
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
         valid <= '0;
      end else if (int'(bus.pos) < NUM_DIGITS) begin
         digit[bus.pos[IDXW-1:0]] <= bus.data;
         valid[bus.pos[IDXW-1:0]] <= 1'b1;
      end
   end

   // Refresh timer: each digit stays selected for REFRESH_DIV cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         tick     <= '0;
         scan_idx <= '0;
      end else if (tick == CNTW'(REFRESH_DIV - 1)) begin
         tick     <= '0;
         scan_idx <= (scan_idx == IDXW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   // Glyph select: error text beats busy dash beats the stored digit
   always_comb begin
      glyph  = GLYPH_BLANK;
      an_nxt = '1;
      if (valid[scan_idx]) glyph = hex_glyph(digit[scan_idx]);
      if (bus.status == 2'b00) begin
         if (scan_idx == IDXW'(2))                                glyph = GLYPH_E;
         else if (scan_idx == IDXW'(1) || scan_idx == IDXW'(0))   glyph = GLYPH_R;
         else                                                     glyph = GLYPH_BLANK;
      end else if (bus.status == 2'b01 && scan_idx == IDXW'(NUM_DIGITS - 1)) begin
         glyph = GLYPH_DASH;
      end
      for (int i = 0; i < NUM_DIGITS; i++) an_nxt[i] = (scan_idx != IDXW'(i));
   end

   // Output register: pins are glitch-free and lag the scan index by one cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         seg_q <= GLYPH_BLANK;
         an_q  <= '1;
      end else begin
         seg_q <= glyph;
         an_q  <= an_nxt;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;
   assign bus.dp  = 1'b1;
endmodule
